// File: rtl/btn_bcd_counter.sv
// Debounced push-button BCD digit: up/down/clear buttons step one digit; carry/borrow pulse on wrap.
// Latency: DEBOUNCE_CYCLES+3 edges from raw press to registered digit; no backpressure (buttons are free-running).
// Optional BTN_BCD_HEX_EN widens the count range to 0-15 (wrap at 15/0 instead of 9/0).
module btn_bcd_counter #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_btn_clr,
    output logic [3:0] o_digit,
    output logic       o_carry,
    output logic       o_borrow
);

    localparam int NCH     = 3;
    localparam int CH_UP   = 0;
    localparam int CH_DOWN = 1;
    localparam int CH_CLR  = 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef BTN_BCD_HEX_EN
    localparam logic [3:0] DIGIT_MAX = 4'd15;
`else
    localparam logic [3:0] DIGIT_MAX = 4'd9;
`endif

    logic [NCH-1:0]   w_btn_raw;
    logic [NCH-1:0]   r_s1;
    logic [NCH-1:0]   r_s2;
    logic [NCH-1:0]   r_db;
    logic [NCH-1:0]   r_db_q;
    logic [CNT_W-1:0] r_cnt [NCH];
    logic [NCH-1:0]   w_press;

    logic [3:0] r_digit;
    logic       r_carry;
    logic       r_borrow;
    logic [3:0] w_digit_nxt;
    logic       w_carry_nxt;
    logic       w_borrow_nxt;

    assign w_btn_raw = {i_btn_clr, i_btn_down, i_btn_up};

    // Synchronizer and debounce: db follows s2 only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_db   <= '0;
            r_db_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1   <= w_btn_raw;
            r_s2   <= r_s1;
            r_db_q <= r_db;
            for (int i = 0; i < NCH; i++) begin
                if (r_s2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_db[i]  <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign w_press = r_db & ~r_db_q;

    // Clear wins over everything; simultaneous up+down cancel out.
    always_comb begin
        w_digit_nxt  = r_digit;
        w_carry_nxt  = 1'b0;
        w_borrow_nxt = 1'b0;
        if (w_press[CH_CLR]) begin
            w_digit_nxt = 4'd0;
        end else if (w_press[CH_UP] && !w_press[CH_DOWN]) begin
            if (r_digit >= DIGIT_MAX) begin
                w_digit_nxt = 4'd0;
                w_carry_nxt = 1'b1;
            end else begin
                w_digit_nxt = r_digit + 4'd1;
            end
        end else if (w_press[CH_DOWN] && !w_press[CH_UP]) begin
            if (r_digit == 4'd0) begin
                w_digit_nxt  = DIGIT_MAX;
                w_borrow_nxt = 1'b1;
            end else begin
                w_digit_nxt = r_digit - 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_digit  <= 4'd0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
        end else begin
            r_digit  <= w_digit_nxt;
            r_carry  <= w_carry_nxt;
            r_borrow <= w_borrow_nxt;
        end
    end

    assign o_digit  = r_digit;
    assign o_carry  = r_carry;
    assign o_borrow = r_borrow;

endmodule

// File: tb/tb_btn_bcd_counter.sv
// Directed bench for btn_bcd_counter with DEBOUNCE_CYCLES=4; inputs change and outputs are sampled on the falling edge.
module tb_btn_bcd_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       btn_clr;
    logic [3:0] digit;
    logic       carry;
    logic       borrow;

    int         n_vec    = 0;
    int         n_err    = 0;
    int         n_carry  = 0;
    int         n_borrow = 0;
    logic [3:0] carry_digit;

    always #5 clk = ~clk;

    btn_bcd_counter #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_btn_up  (btn_up),
        .i_btn_down(btn_down),
        .i_btn_clr (btn_clr),
        .o_digit   (digit),
        .o_carry   (carry),
        .o_borrow  (borrow)
    );

    // Each step passes one rising edge and samples outputs at the following falling edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (carry === 1'b1) begin
                n_carry++;
                carry_digit = digit;
            end
            if (borrow === 1'b1) n_borrow++;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic up, input logic down, input logic clr);
        btn_up   = up;
        btn_down = down;
        btn_clr  = clr;
        step(8);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_clr  = 1'b0;
        step(8);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        n_carry  = 0;
        n_borrow = 0;
    endtask

    initial begin
        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_clr  = 1'b0;
        step(2);
        chk("reset_digit", {4'd0, digit}, 8'd0);
        chk("reset_carry", {7'd0, carry}, 8'd0);
        chk("reset_borrow", {7'd0, borrow}, 8'd0);
        rst = 1'b0;
        step(1);
        n_carry  = 0;
        n_borrow = 0;

        // Held up button: digit steps exactly at edge 6
        btn_up = 1'b1;
        step(6);
        chk("hold_edge5_digit", {4'd0, digit}, 8'd0);
        step(1);
        chk("hold_edge6_digit", {4'd0, digit}, 8'd1);
        step(4);
        chk("hold_no_repeat", {4'd0, digit}, 8'd1);
        btn_up = 1'b0;
        step(8);
        chk("hold_carry_cnt", 8'(n_carry), 8'd0);

        // Short glitch is rejected
        do_reset();
        btn_up = 1'b1;
        step(3);
        btn_up = 1'b0;
        step(10);
        chk("glitch_digit", {4'd0, digit}, 8'd0);
        chk("glitch_carry_cnt", 8'(n_carry), 8'd0);
        chk("glitch_borrow_cnt", 8'(n_borrow), 8'd0);

        // Ten up presses: 1..9 then 0 with one carry at the wrap
        for (int p = 1; p <= 10; p++) begin
            n_carry = 0;
            press(1'b1, 1'b0, 1'b0);
            chk($sformatf("up%0d_digit", p), {4'd0, digit}, 8'(p % 10));
            chk($sformatf("up%0d_carry_cnt", p), 8'(n_carry), (p == 10) ? 8'd1 : 8'd0);
        end
        chk("wrap_carry_digit", {4'd0, carry_digit}, 8'd0);

        // Down from 0 wraps to 9 with borrow, then 8 without
        n_borrow = 0;
        press(1'b0, 1'b1, 1'b0);
        chk("down_wrap_digit", {4'd0, digit}, 8'd9);
        chk("down_wrap_borrow_cnt", 8'(n_borrow), 8'd1);
        n_borrow = 0;
        press(1'b0, 1'b1, 1'b0);
        chk("down2_digit", {4'd0, digit}, 8'd8);
        chk("down2_borrow_cnt", 8'(n_borrow), 8'd0);

        // Bring digit to 5, then simultaneous presses
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk("down_to5_digit", {4'd0, digit}, 8'd5);
        n_carry  = 0;
        n_borrow = 0;
        press(1'b1, 1'b1, 1'b0);
        chk("updown_digit", {4'd0, digit}, 8'd5);
        chk("updown_pulses", 8'(n_carry + n_borrow), 8'd0);
        press(1'b1, 1'b1, 1'b1);
        chk("all3_digit", {4'd0, digit}, 8'd0);
        chk("all3_pulses", 8'(n_carry + n_borrow), 8'd0);

        // Reset at digit 7 with up mid-debounce, button held through reset
        for (int p = 0; p < 7; p++) press(1'b1, 1'b0, 1'b0);
        chk("pre_rst_digit", {4'd0, digit}, 8'd7);
        btn_up = 1'b1;
        step(4);
        rst = 1'b1;
        step(1);
        chk("rst_mid_digit", {4'd0, digit}, 8'd0);
        rst = 1'b0;
        step(6);
        chk("rst_held_edge5", {4'd0, digit}, 8'd0);
        step(1);
        chk("rst_held_edge6", {4'd0, digit}, 8'd1);
        btn_up = 1'b0;
        step(8);

        // Reset mid-debounce with the button released: no step
        btn_up = 1'b1;
        step(4);
        rst    = 1'b1;
        btn_up = 1'b0;
        step(1);
        rst = 1'b0;
        n_carry = 0;
        step(12);
        chk("rst_rel_digit", {4'd0, digit}, 8'd0);
        chk("rst_rel_carry_cnt", 8'(n_carry), 8'd0);

`ifdef BTN_BCD_HEX_EN
        do_reset();
        for (int p = 1; p <= 16; p++) begin
            press(1'b1, 1'b0, 1'b0);
            chk($sformatf("hex_up%0d_digit", p), {4'd0, digit}, 8'(p % 16));
        end
        chk("hex_carry_cnt", 8'(n_carry), 8'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
